// File: rtl/i2c_reg_ctrl.sv
// Register-bank controller behind an I2C slave byte interface: pointer phase,
// auto-incrementing data bytes, and a lower-priority local access port.
module i2c_reg_ctrl #(
  parameter int ADDR_W = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              i2c_start,
  input  logic              i2c_rw,
  input  logic              i2c_stop,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              tx_req,
  output logic [7:0]        tx_data,
  input  logic              loc_req,
  input  logic              loc_we,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic [7:0]        loc_wdata,
  output logic [7:0]        loc_rdata,
  output logic              loc_ack,
  output logic              upd,
  output logic [ADDR_W-1:0] upd_addr,
  output logic [ADDR_W-1:0] reg_ptr,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, PTR, WR, RD} state_t;

  state_t            r_state;
  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_ptr;
  logic [7:0]        r_tx_data;
  logic [7:0]        r_loc_rdata;
  logic              r_loc_ack;
  logic              r_upd;
  logic [ADDR_W-1:0] r_upd_addr;
  logic              w_loc_accept;

  // The local port only gets the bank when no I2C transaction is open or opening.
  assign w_loc_accept = loc_req && (r_state == IDLE) && !i2c_start;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_tx_data   <= '0;
      r_loc_rdata <= '0;
      r_loc_ack   <= 1'b0;
      r_upd       <= 1'b0;
      r_upd_addr  <= '0;
      // NOTE: the bank must read back as 0x00 after reset, so it is built from
      // resettable flops rather than a RAM macro.
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      // NOTE: non-blocking throughout, so every read of r_mem/r_ptr below sees
      // the pre-edge value; tx_data therefore lags a write by one extra cycle.
      r_upd     <= 1'b0;
      r_loc_ack <= w_loc_accept;
      r_tx_data <= r_mem[r_ptr];

      if (w_loc_accept) begin
        if (loc_we) r_mem[loc_addr] <= loc_wdata;
        else        r_loc_rdata     <= r_mem[loc_addr];
      end

      case (r_state)
        PTR: begin
          if (rx_valid) begin
            r_ptr   <= rx_data[ADDR_W-1:0];
            r_state <= WR;
          end
        end
        WR: begin
          if (rx_valid) begin
            r_mem[r_ptr] <= rx_data;
            r_upd        <= 1'b1;
            r_upd_addr   <= r_ptr;
            r_ptr        <= r_ptr + ADDR_W'(1);
          end
        end
        RD: begin
          if (tx_req) r_ptr <= r_ptr + ADDR_W'(1);
        end
        default: ;
      endcase

      // Bus events override the byte-driven transition; start beats stop.
      if (i2c_start)     r_state <= i2c_rw ? RD : PTR;
      else if (i2c_stop) r_state <= IDLE;
    end
  end

  assign tx_data   = r_tx_data;
  assign loc_rdata = r_loc_rdata;
  assign loc_ack   = r_loc_ack;
  assign upd       = r_upd;
  assign upd_addr  = r_upd_addr;
  assign reg_ptr   = r_ptr;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Directed self-checking bench for i2c_reg_ctrl; inputs change and outputs
// are observed on the falling clock edge.
module tb_i2c_reg_ctrl;

  localparam int ADDR_W = 4;

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic              i2c_start, i2c_rw, i2c_stop;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              tx_req;
  logic [7:0]        tx_data;
  logic              loc_req, loc_we;
  logic [ADDR_W-1:0] loc_addr;
  logic [7:0]        loc_wdata, loc_rdata;
  logic              loc_ack;
  logic              upd;
  logic [ADDR_W-1:0] upd_addr, reg_ptr;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] rd;
  int         waits;

  i2c_reg_ctrl #(.ADDR_W(ADDR_W)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .i2c_start (i2c_start),
    .i2c_rw    (i2c_rw),
    .i2c_stop  (i2c_stop),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_req    (tx_req),
    .tx_data   (tx_data),
    .loc_req   (loc_req),
    .loc_we    (loc_we),
    .loc_addr  (loc_addr),
    .loc_wdata (loc_wdata),
    .loc_rdata (loc_rdata),
    .loc_ack   (loc_ack),
    .upd       (upd),
    .upd_addr  (upd_addr),
    .reg_ptr   (reg_ptr),
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input logic rw);
    @(negedge sys_clk);
    i2c_start = 1'b1;
    i2c_rw    = rw;
    @(negedge sys_clk);
    i2c_start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge sys_clk);
    i2c_stop = 1'b1;
    @(negedge sys_clk);
    i2c_stop = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] d);
    @(negedge sys_clk);
    rx_valid = 1'b1;
    rx_data  = d;
    @(negedge sys_clk);
    rx_valid = 1'b0;
  endtask

  // Lets tx_data settle, captures it in the tx_req cycle as the slave would.
  task automatic tx_read(output logic [7:0] d);
    repeat (3) @(negedge sys_clk);
    d      = tx_data;
    tx_req = 1'b1;
    @(negedge sys_clk);
    tx_req = 1'b0;
  endtask

  task automatic loc_access(input logic we, input logic [ADDR_W-1:0] addr,
                            input logic [7:0] wd, output logic [7:0] rdata,
                            output int n_wait);
    @(negedge sys_clk);
    loc_req   = 1'b1;
    loc_we    = we;
    loc_addr  = addr;
    loc_wdata = wd;
    n_wait    = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge sys_clk);
      if (loc_ack) begin
        n_wait = i;
        break;
      end
    end
    if (n_wait == 0) check("loc_timeout", 32'd0, 32'd1);
    loc_req = 1'b0;
    rdata   = loc_rdata;
  endtask

  initial begin
    sys_rst = 1'b1;
    i2c_start = 0; i2c_rw = 0; i2c_stop = 0; rx_valid = 0; rx_data = '0;
    tx_req = 0; loc_req = 0; loc_we = 0; loc_addr = '0; loc_wdata = '0;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    check("rst_tx_data", tx_data, 8'h00);
    check("rst_loc_rdata", loc_rdata, 8'h00);
    check("rst_loc_ack", loc_ack, 1'b0);
    check("rst_upd", upd, 1'b0);
    check("rst_upd_addr", upd_addr, 4'd0);
    check("rst_reg_ptr", reg_ptr, 4'd0);
    check("rst_busy", busy, 1'b0);

    // Write sequence: pointer 3, data A5 5A.
    pulse_start(1'b0);
    check("wr_busy", busy, 1'b1);
    rx_byte(8'h03);
    check("wr_ptr_no_upd", upd, 1'b0);
    check("wr_ptr_set", reg_ptr, 4'd3);
    rx_byte(8'hA5);
    check("wr_upd0", upd, 1'b1);
    check("wr_upd_addr0", upd_addr, 4'd3);
    check("wr_ptr_inc0", reg_ptr, 4'd4);
    rx_byte(8'h5A);
    check("wr_upd1", upd, 1'b1);
    check("wr_upd_addr1", upd_addr, 4'd4);
    pulse_stop();
    check("wr_stop_busy", busy, 1'b0);
    check("wr_final_ptr", reg_ptr, 4'd5);
    loc_access(1'b0, 4'd3, 8'h00, rd, waits);
    check("loc_rd3", rd, 8'hA5);
    check("loc_rd3_latency", waits, 1);
    loc_access(1'b0, 4'd4, 8'h00, rd, waits);
    check("loc_rd4", rd, 8'h5A);

    // Read with wrap from 14 through 15 to 0.
    loc_access(1'b1, 4'd14, 8'h11, rd, waits);
    loc_access(1'b1, 4'd15, 8'h22, rd, waits);
    loc_access(1'b1, 4'd0,  8'h33, rd, waits);
    check("loc_wr_no_ptr_change", reg_ptr, 4'd5);
    pulse_start(1'b0);
    rx_byte(8'h0E);
    pulse_start(1'b1);
    tx_read(rd); check("rd_wrap0", rd, 8'h11);
    tx_read(rd); check("rd_wrap1", rd, 8'h22);
    tx_read(rd); check("rd_wrap2", rd, 8'h33);
    @(negedge sys_clk);
    check("rd_wrap_ptr", reg_ptr, 4'd1);
    pulse_stop();

    // Local write held off while the I2C write transaction is open.
    pulse_start(1'b0);
    rx_byte(8'h08);
    @(negedge sys_clk);
    loc_req = 1'b1; loc_we = 1'b1; loc_addr = 4'd7; loc_wdata = 8'hC3;
    waits = 0;
    repeat (5) begin
      @(negedge sys_clk);
      if (loc_ack) waits++;
    end
    check("prio_no_ack_busy", waits, 0);
    i2c_stop = 1'b1;
    @(negedge sys_clk);
    i2c_stop = 1'b0;
    check("prio_no_ack_stop", loc_ack, 1'b0);
    @(negedge sys_clk);
    check("prio_ack_after_idle", loc_ack, 1'b1);
    loc_req = 1'b0;
    loc_access(1'b0, 4'd7, 8'h00, rd, waits);
    check("prio_rd7", rd, 8'hC3);

    // rx_valid together with stop commits the byte and closes.
    pulse_start(1'b0);
    rx_byte(8'h02);
    @(negedge sys_clk);
    rx_valid = 1'b1; rx_data = 8'h9C; i2c_stop = 1'b1;
    @(negedge sys_clk);
    rx_valid = 1'b0; i2c_stop = 1'b0;
    check("col_rx_stop_busy", busy, 1'b0);
    check("col_rx_stop_upd", upd, 1'b1);
    check("col_rx_stop_addr", upd_addr, 4'd2);
    check("col_rx_stop_ptr", reg_ptr, 4'd3);
    loc_access(1'b0, 4'd2, 8'h00, rd, waits);
    check("col_rd2", rd, 8'h9C);

    // start(rw=1) together with stop lands in RD.
    @(negedge sys_clk);
    i2c_start = 1'b1; i2c_rw = 1'b1; i2c_stop = 1'b1;
    @(negedge sys_clk);
    i2c_start = 1'b0; i2c_stop = 1'b0;
    check("col_start_stop_busy", busy, 1'b1);
    tx_read(rd);
    @(negedge sys_clk);
    check("col_start_stop_rd_inc", reg_ptr, 4'd4);
    pulse_stop();

    // loc_req in the same cycle as start is refused.
    @(negedge sys_clk);
    i2c_start = 1'b1; i2c_rw = 1'b0;
    loc_req = 1'b1; loc_we = 1'b1; loc_addr = 4'd9; loc_wdata = 8'h77;
    @(negedge sys_clk);
    i2c_start = 1'b0; loc_req = 1'b0;
    check("col_loc_start_ack", loc_ack, 1'b0);
    check("col_loc_start_busy", busy, 1'b1);
    pulse_stop();
    loc_access(1'b0, 4'd9, 8'h00, rd, waits);
    check("col_loc_start_rd9", rd, 8'h00);

    // Reset in the middle of a write transaction.
    loc_access(1'b0, 4'd2, 8'h00, rd, waits);
    check("pre_rst_rd2", rd, 8'h9C);
    pulse_start(1'b0);
    rx_byte(8'h06);
    rx_byte(8'hEE);
    sys_rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ptr", reg_ptr, 4'd0);
    check("mid_rst_upd", upd, 1'b0);
    check("mid_rst_upd_addr", upd_addr, 4'd0);
    check("mid_rst_loc_rdata", loc_rdata, 8'h00);
    check("mid_rst_tx_data", tx_data, 8'h00);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    loc_access(1'b0, 4'd6, 8'h00, rd, waits);
    check("post_rst_rd6", rd, 8'h00);
    loc_access(1'b0, 4'd3, 8'h00, rd, waits);
    check("post_rst_rd3", rd, 8'h00);

    // Upper pointer bits ignored; normal transaction after reset.
    pulse_start(1'b0);
    rx_byte(8'hF5);
    check("ptr_upper_bits", reg_ptr, 4'd5);
    rx_byte(8'h42);
    check("post_rst_upd_addr", upd_addr, 4'd5);
    check("post_rst_ptr", reg_ptr, 4'd6);
    pulse_stop();
    loc_access(1'b0, 4'd5, 8'h00, rd, waits);
    check("post_rst_rd5", rd, 8'h42);

    // Local write shows up in tx_data when it targets the pointer.
    loc_access(1'b1, 4'd6, 8'hB7, rd, waits);
    @(negedge sys_clk);
    check("loc_wr_tx_data", tx_data, 8'hB7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
